fpu_rt_sched: RTL and testbench
===============================

Name: fpu_rt_sched

Overview:
Scheduler for the pool of iterative radix-2 sqrt/div units (rt2_fp) in the FP backend.
- Accepts one sqrt/div request per cycle into a single-entry holding buffer.
- Decodes op into step count, type and root flag, then starts the lowest-numbered free unit.
- Round-robin arbitrates finished units onto the single writeback port and emits a delayed data-select for the result tri-state mux.

Parameters:
NUNITS, 4, number of rt2_fp units (2..8)
REG_WIDTH, 9, destination register tag width
II_WIDTH, 10, instruction index width
OP_WIDTH, 13, op code width
DATA_LAT, 5, cycles from writeback grant to result data valid

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
except  in  1  pipeline flush
req_en  in  1  request valid
req_op  in  OP_WIDTH  operation; [7:0] decoded with fop_sqrt*/fop_div* macros
req_reg  in  REG_WIDTH  destination tag
req_II  in  II_WIDTH  instruction index
req_pause  out  1  buffer full; upstream must not assert req_en
unit_rdy  in  NUNITS  unit idle (rt2_fp rdy)
unit_start  out  NUNITS  one-hot start pulse
start_reg  out  REG_WIDTH  tag to started unit
start_II  out  II_WIDTH  index to started unit
start_op  out  OP_WIDTH  op to started unit
start_steps  out  5  iteration count
start_type  out  3  0=double, 1=extended, 2=single
start_root  out  1  1=sqrt, 0=div
unit_done  in  NUNITS  result pending (rt2_fp out_en)
unit_ack  out  NUNITS  one-hot grant (rt2_fp out_can)
wb_en  out  1  writeback valid this cycle
wb_unit  out  3  granted unit index
data_sel  out  NUNITS  one-hot result select, DATA_LAT after grant; 0 = drive zero

Behaviour:
- Reset: all outputs 0; buffer empty; reserved=0; rr pointer=0; data_sel pipeline cleared.
- Buffer: 1 entry. Load on req_en && !full. req_pause = full (registered). If req_en arrives while full, the request is dropped and a sim assertion fires.
- Free unit: free[n] = unit_rdy[n] & ~reserved[n].
- Start: when the buffer is full and any unit is free, pulse unit_start on the lowest free n for one cycle, drive start_* from the buffer, and empty it in the same cycle. A request loaded in cycle t starts no earlier than cycle t+1.
- Reservation: reserved[n] sets on start and clears on cycle of unit_ack[n]. This covers the rdy deassert lag.
- Decode:
  - sqrtD/divD (DL or DH): steps=13, type=0.
  - sqrtE/divE: steps=16, type=1.
  - sqrtS/divS: steps=6, type=2.
  - start_root=1 for any sqrt.
  - Unknown op: request discarded, no start issued.
- Writeback: each cycle grant at most one unit with done[n] & reserved[n], round-robin from pointer p. Drive unit_ack one-hot (combinational), wb_en=1, wb_unit=n. Then set p = n+1 mod NUNITS. No done → wb_en=0, unit_ack=0.
- data_sel: unit_ack delayed by exactly DATA_LAT registers.
- Start and ack on the same unit in the same cycle cannot occur (reserved unit is never free).
- Simultaneous start on unit a and ack on unit b is allowed.
- except (registered effect at next edge):
  - Buffer emptied; reserved cleared.
  - unit_done masked in the except cycle.
  - Pending data_sel entries still shift out.
- rst mid-operation: immediate return to reset state; in-flight data_sel dropped.

Test Plan:
- Reset, then req sqrtDL with all unit_rdy=1 at t=0 → unit_start=0001 at t=1, steps=13, type=0, root=1; req_pause=1 during t=1 only.
- Two back-to-back divS, unit0 reserved → starts on 0010 then 0100, steps=6, type=2, root=0.
- unit_done=1011 held, p=0 → acks 0001, 0010, 1000 in successive cycles; data_sel mirrors each 5 cycles later; wb_unit=0,1,3.
- All units reserved, req divE held in buffer → req_pause=1; unit2 acked then rdy → start 0100, steps=16, type=1.
- except while buffer full and two units reserved → next cycle buffer empty, reserved=0, no start, unit_done ignored that cycle.
- rst asserted 2 cycles after a grant → data_sel stays 0 thereafter; all outputs 0.

Source files
------------

// File: rtl/fpu_rt_sched.sv
// Issue/writeback scheduler for the pool of radix-2 sqrt/div units: one-entry request buffer,
// lowest-free-unit start, and round-robin writeback grant with a delayed result-select pipe.
module fpu_rt_sched #(
  parameter int NUNITS    = 4,
  parameter int REG_WIDTH = 9,
  parameter int II_WIDTH  = 10,
  parameter int OP_WIDTH  = 13,
  parameter int DATA_LAT  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 except,
  input  logic                 req_en,
  input  logic [OP_WIDTH-1:0]  req_op,
  input  logic [REG_WIDTH-1:0] req_reg,
  input  logic [II_WIDTH-1:0]  req_II,
  output logic                 req_pause,
  input  logic [NUNITS-1:0]    unit_rdy,
  output logic [NUNITS-1:0]    unit_start,
  output logic [REG_WIDTH-1:0] start_reg,
  output logic [II_WIDTH-1:0]  start_II,
  output logic [OP_WIDTH-1:0]  start_op,
  output logic [4:0]           start_steps,
  output logic [2:0]           start_type,
  output logic                 start_root,
  input  logic [NUNITS-1:0]    unit_done,
  output logic [NUNITS-1:0]    unit_ack,
  output logic                 wb_en,
  output logic [2:0]           wb_unit,
  output logic [NUNITS-1:0]    data_sel
);

  // Low-byte op encodings of the fop_sqrt*/fop_div* family.
  localparam logic [7:0] FOP_SQRTDL = 8'h40;
  localparam logic [7:0] FOP_SQRTDH = 8'h41;
  localparam logic [7:0] FOP_SQRTE  = 8'h42;
  localparam logic [7:0] FOP_SQRTS  = 8'h43;
  localparam logic [7:0] FOP_DIVDL  = 8'h48;
  localparam logic [7:0] FOP_DIVDH  = 8'h49;
  localparam logic [7:0] FOP_DIVE   = 8'h4A;
  localparam logic [7:0] FOP_DIVS   = 8'h4B;

  // Result layout: {valid, steps[4:0], type[2:0], root}.
  function automatic logic [9:0] decode_op(input logic [7:0] op);
    logic [9:0] d;
    d = '0;
    case (op)
      FOP_SQRTDL, FOP_SQRTDH: d = {1'b1, 5'd13, 3'd0, 1'b1};
      FOP_DIVDL,  FOP_DIVDH:  d = {1'b1, 5'd13, 3'd0, 1'b0};
      FOP_SQRTE:              d = {1'b1, 5'd16, 3'd1, 1'b1};
      FOP_DIVE:               d = {1'b1, 5'd16, 3'd1, 1'b0};
      FOP_SQRTS:              d = {1'b1, 5'd6,  3'd2, 1'b1};
      FOP_DIVS:               d = {1'b1, 5'd6,  3'd2, 1'b0};
      default:                d = '0;
    endcase
    return d;
  endfunction

  logic                 full_q, full_d;
  logic [NUNITS-1:0]    rsv_q, rsv_d;
  logic [2:0]           rr_q, rr_d;
  logic [OP_WIDTH-1:0]  buf_op_q;
  logic [REG_WIDTH-1:0] buf_reg_q;
  logic [II_WIDTH-1:0]  buf_II_q;
  logic [4:0]           buf_steps_q;
  logic [2:0]           buf_type_q;
  logic                 buf_root_q;
  logic [NUNITS-1:0]    dsel_q [DATA_LAT];

  logic [9:0]           dec;
  logic                 load;
  logic                 go;
  logic                 found;
  logic                 starting;
  logic [NUNITS-1:0]    free;
  logic [NUNITS-1:0]    start_oh;
  logic [NUNITS-1:0]    elig;
  logic [2*NUNITS-1:0]  elig2;
  logic [NUNITS-1:0]    ack_oh;
  logic                 grant;
  int                   gsum;
  logic [2:0]           gidx;

  assign dec  = decode_op(req_op[7:0]);
  assign load = req_en & ~full_q & dec[9] & ~except & ~rst;

  // Issue: lowest-numbered unit that is idle and not already holding a started op.
  always_comb begin
    free     = unit_rdy & ~rsv_q;
    go       = full_q & ~except & ~rst;
    start_oh = '0;
    found    = 1'b0;
    for (int k = 0; k < NUNITS; k++) begin
      if (go && !found && free[k]) begin
        start_oh[k] = 1'b1;
        found       = 1'b1;
      end
    end
    starting = found;
  end

  // Writeback: rotate the eligible set so bit 0 is the pointer, then take the first hit.
  always_comb begin
    elig  = unit_done & rsv_q & {NUNITS{~except & ~rst}};
    elig2 = {elig, elig} >> rr_q;
    grant = 1'b0;
    gsum  = 0;
    for (int k = 0; k < NUNITS; k++) begin
      if (!grant && elig2[k]) begin
        grant = 1'b1;
        gsum  = int'(rr_q) + k;
      end
    end
    if (gsum >= NUNITS) gsum = gsum - NUNITS;
    gidx   = 3'(gsum);
    ack_oh = grant ? ({{(NUNITS-1){1'b0}}, 1'b1} << gidx) : '0;
    rr_d   = rr_q;
    if (grant) rr_d = (gidx == 3'(NUNITS-1)) ? 3'd0 : gidx + 3'd1;
  end

  always_comb begin
    full_d = full_q;
    rsv_d  = (rsv_q | start_oh) & ~ack_oh;
    if (except) begin
      full_d = 1'b0;
      rsv_d  = '0;
    end else if (starting) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      rsv_q  <= '0;
      rr_q   <= '0;
    end else begin
      full_q <= full_d;
      rsv_q  <= rsv_d;
      rr_q   <= rr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      buf_op_q    <= req_op;
      buf_reg_q   <= req_reg;
      buf_II_q    <= req_II;
      buf_steps_q <= dec[8:4];
      buf_type_q  <= dec[3:1];
      buf_root_q  <= dec[0];
    end
  end

  // Result-select delay line; flush leaves it running, reset drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DATA_LAT; s++) dsel_q[s] <= '0;
    end else begin
      dsel_q[0] <= ack_oh;
      for (int s = 1; s < DATA_LAT; s++) dsel_q[s] <= dsel_q[s-1];
    end
  end

  always @(posedge clk) begin
    if (!rst) assert (!(req_en && full_q));
  end

  assign req_pause   = full_q;
  assign unit_start  = start_oh;
  assign start_reg   = starting ? buf_reg_q   : '0;
  assign start_II    = starting ? buf_II_q    : '0;
  assign start_op    = starting ? buf_op_q    : '0;
  assign start_steps = starting ? buf_steps_q : '0;
  assign start_type  = starting ? buf_type_q  : '0;
  assign start_root  = starting & buf_root_q;
  assign unit_ack    = ack_oh;
  assign wb_en       = grant;
  assign wb_unit     = grant ? gidx : 3'd0;
  assign data_sel    = dsel_q[DATA_LAT-1];

endmodule

// File: tb/tb_fpu_rt_sched.sv
// Directed bench for fpu_rt_sched: issue, reservation, round-robin writeback, flush and reset.
`timescale 1ns/1ps
module tb_fpu_rt_sched;

  localparam logic [12:0] OP_SQRTDL = 13'h040;
  localparam logic [12:0] OP_SQRTDH = 13'h041;
  localparam logic [12:0] OP_SQRTE  = 13'h042;
  localparam logic [12:0] OP_SQRTS  = 13'h043;
  localparam logic [12:0] OP_DIVDL  = 13'h048;
  localparam logic [12:0] OP_DIVDH  = 13'h049;
  localparam logic [12:0] OP_DIVE   = 13'h04A;
  localparam logic [12:0] OP_DIVS   = 13'h04B;

  logic        clk = 1'b0;
  logic        rst, except, req_en;
  logic [12:0] req_op;
  logic [8:0]  req_reg;
  logic [9:0]  req_II;
  logic        req_pause;
  logic [3:0]  unit_rdy, unit_start, unit_done, unit_ack, data_sel;
  logic [8:0]  start_reg;
  logic [9:0]  start_II;
  logic [12:0] start_op;
  logic [4:0]  start_steps;
  logic [2:0]  start_type, wb_unit;
  logic        start_root, wb_en;

  int checks = 0;
  int errors = 0;

  int ack_exp  [9] = '{1, 2, 8, 0, 0, 0, 0, 0, 0};
  int wbu_exp  [9] = '{0, 1, 3, 0, 0, 0, 0, 0, 0};
  int dsel_exp [9] = '{0, 0, 0, 0, 0, 1, 2, 8, 0};

  always #5 clk = ~clk;

  fpu_rt_sched #(
    .NUNITS(4), .REG_WIDTH(9), .II_WIDTH(10), .OP_WIDTH(13), .DATA_LAT(5)
  ) dut (
    .clk(clk), .rst(rst), .except(except),
    .req_en(req_en), .req_op(req_op), .req_reg(req_reg), .req_II(req_II),
    .req_pause(req_pause), .unit_rdy(unit_rdy), .unit_start(unit_start),
    .start_reg(start_reg), .start_II(start_II), .start_op(start_op),
    .start_steps(start_steps), .start_type(start_type), .start_root(start_root),
    .unit_done(unit_done), .unit_ack(unit_ack), .wb_en(wb_en), .wb_unit(wb_unit),
    .data_sel(data_sel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, then check the start pulse on the following cycle.
  task automatic issue(input string tag, input logic [12:0] op, input logic [8:0] rg,
                       input logic [9:0] ii, input int exp_start, input int exp_steps,
                       input int exp_type, input int exp_root);
    req_en = 1'b1; req_op = op; req_reg = rg; req_II = ii;
    #1;
    check({tag, "_nostart"}, 32'(unit_start), 0);
    step();
    req_en = 1'b0;
    #1;
    check({tag, "_start"}, 32'(unit_start), 32'(exp_start));
    check({tag, "_steps"}, 32'(start_steps), 32'(exp_steps));
    check({tag, "_type"},  32'(start_type), 32'(exp_type));
    check({tag, "_root"},  32'(start_root), 32'(exp_root));
    check({tag, "_reg"},   32'(start_reg), 32'(rg));
    check({tag, "_II"},    32'(start_II), 32'(ii));
    check({tag, "_pause"}, 32'(req_pause), 1);
    step();
  endtask

  initial begin
    rst = 1'b1; except = 1'b0; req_en = 1'b0; req_op = '0; req_reg = '0; req_II = '0;
    unit_rdy = 4'hF; unit_done = 4'h0;
    step(); step();
    #1;
    check("rst_start", 32'(unit_start), 0);
    check("rst_pause", 32'(req_pause), 0);
    check("rst_ack",   32'(unit_ack), 0);
    check("rst_wben",  32'(wb_en), 0);
    check("rst_dsel",  32'(data_sel), 0);
    check("rst_steps", 32'(start_steps), 0);
    step();
    rst = 1'b0;

    // sqrtDL into an idle pool lands on unit 0
    issue("t1", OP_SQRTDL, 9'd5, 10'd7, 1, 13, 0, 1);
    #1;
    check("t1_pause_clear", 32'(req_pause), 0);

    // unknown op is discarded
    req_en = 1'b1; req_op = 13'h0FF; req_reg = 9'd1; req_II = 10'd1;
    step();
    req_en = 1'b0;
    #1;
    check("unk_pause", 32'(req_pause), 0);
    check("unk_start", 32'(unit_start), 0);
    step();

    // unit 0 reserved: divS goes to 1 then 2
    issue("t2a", OP_DIVS, 9'd10, 10'd20, 2, 6, 2, 0);
    issue("t2b", OP_DIVS, 9'd11, 10'd21, 4, 6, 2, 0);
    issue("t3r", OP_SQRTDH, 9'd12, 10'd22, 8, 13, 0, 1);

    // done=1011 held with pointer 0
    unit_done = 4'b1011;
    for (int c = 0; c < 9; c++) begin
      #1;
      check("t3_ack",  32'(unit_ack), 32'(ack_exp[c]));
      check("t3_wben", 32'(wb_en), (ack_exp[c] != 0) ? 1 : 0);
      check("t3_wbu",  32'(wb_unit), 32'(wbu_exp[c]));
      check("t3_dsel", 32'(data_sel), 32'(dsel_exp[c]));
      step();
    end
    unit_done = 4'h0;

    // refill units 0,1,3 so the whole pool is reserved
    issue("t4a", OP_SQRTE, 9'd13, 10'd23, 1, 16, 1, 1);
    issue("t4b", OP_DIVDL, 9'd14, 10'd24, 2, 13, 0, 0);
    issue("t4c", OP_SQRTS, 9'd15, 10'd25, 8, 6, 2, 1);
    req_en = 1'b1; req_op = OP_DIVE; req_reg = 9'd33; req_II = 10'd44;
    step();
    req_en = 1'b0;
    #1;
    check("t4_hold_pause", 32'(req_pause), 1);
    check("t4_hold_start", 32'(unit_start), 0);
    step();
    #1;
    check("t4_hold2_pause", 32'(req_pause), 1);
    check("t4_hold2_start", 32'(unit_start), 0);
    unit_done = 4'b0100;
    #1;
    check("t4_ack",     32'(unit_ack), 4);
    check("t4_wbu",     32'(wb_unit), 2);
    check("t4_ack_nst", 32'(unit_start), 0);
    step();
    unit_done = 4'h0;
    #1;
    check("t4_start", 32'(unit_start), 4);
    check("t4_steps", 32'(start_steps), 16);
    check("t4_type",  32'(start_type), 1);
    check("t4_root",  32'(start_root), 0);
    check("t4_reg",   32'(start_reg), 33);
    step();
    #1;
    check("t4_pause_clear", 32'(req_pause), 0);

    // release units 0 and 1 (pointer at 3), leaving 2 and 3 reserved
    unit_done = 4'b0011;
    #1;
    check("t5_ack0", 32'(unit_ack), 1);
    check("t5_wbu0", 32'(wb_unit), 0);
    step();
    #1;
    check("t5_ack1", 32'(unit_ack), 2);
    check("t5_wbu1", 32'(wb_unit), 1);
    step();
    unit_done = 4'h0;
    unit_rdy  = 4'b1100;
    req_en = 1'b1; req_op = OP_DIVDH; req_reg = 9'd50; req_II = 10'd60;
    step();
    req_en = 1'b0;
    #1;
    check("t5_full",  32'(req_pause), 1);
    check("t5_nost",  32'(unit_start), 0);
    step();
    except    = 1'b1;
    unit_done = 4'b1100;
    #1;
    check("t5_exc_ack",  32'(unit_ack), 0);
    check("t5_exc_wben", 32'(wb_en), 0);
    check("t5_exc_st",   32'(unit_start), 0);
    step();
    except   = 1'b0;
    unit_rdy = 4'hF;
    #1;
    check("t5_post_pause", 32'(req_pause), 0);
    check("t5_post_start", 32'(unit_start), 0);
    check("t5_post_ack",   32'(unit_ack), 0);
    step();
    unit_done = 4'h0;
    repeat (8) step();

    // reset two cycles after a grant drops the pending select
    issue("t6", OP_SQRTS, 9'd70, 10'd80, 1, 6, 2, 1);
    unit_done = 4'b0001;
    #1;
    check("t6_ack",  32'(unit_ack), 1);
    check("t6_wben", 32'(wb_en), 1);
    step();
    unit_done = 4'h0;
    #1;
    check("t6_idle", 32'(wb_en), 0);
    step();
    rst = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      check("t6_dsel", 32'(data_sel), 0);
      step();
    end
    #1;
    check("t6_rst_start", 32'(unit_start), 0);
    check("t6_rst_ack",   32'(unit_ack), 0);
    check("t6_rst_pause", 32'(req_pause), 0);
    check("t6_rst_wben",  32'(wb_en), 0);
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
